multi_in_multi_out_fifo_lib: RTL and testbench

- Parametrised circular FIFO that accepts up to IN_NUM entries and releases up to OUT_NUM entries per cycle, in strict order.
- Overwrite is selectable at elaboration. With OVERWRITE=1, the oldest entries are dropped when the FIFO overflows. With OVERWRITE=0, a ready/backpressure interface is used.
- Intended as the general issue/dispatch buffer between multi-lane producer and consumer stages.

---
 rtl/fifo_lib_pkg.sv | 20 ++
 rtl/multi_in_multi_out_fifo_lib_if.sv | 44 ++++
 rtl/lead_ones_cnt.sv | 21 ++
 rtl/multi_in_multi_out_fifo_lib.sv | 140 ++++++++++++++
 tb/tb_multi_in_multi_out_fifo_lib.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_lib_pkg.sv
// Shared helpers for the multi-lane FIFO library.
//   - ptr_width : width of a wrap-aware pointer / occupancy counter for a given depth
//   - idx_add   : modulo add used to map base pointer + lane offset to a storage index
//   - DROP_CNT_W / DROP_CNT_MAX : overflow statistics counter geometry
package fifo_lib_pkg;

  localparam int unsigned DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  // One extra bit over the index so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned ent_num);
    return $clog2(ent_num) + 1;
  endfunction

  function automatic int unsigned idx_add(input int unsigned base, input int unsigned off,
                                          input int unsigned ent_num);
    return (base + off) % ent_num;
  endfunction

endpackage

// File: rtl/multi_in_multi_out_fifo_lib_if.sv
// Handshake bundle between multi-lane producer/consumer and the FIFO.
//   master : producer/consumer side (drives in_vld, in_data, pick_rdy)
//   slave  : FIFO side (drives in_rdy, out_vld, out_data, fifo_full, ent_cnt)
// With FIFO_OVF_STAT_EN defined the bundle also carries stat_clr, ovf_flag, drop_cnt.
interface multi_in_multi_out_fifo_lib_if
  import fifo_lib_pkg::*;
#(
  parameter int unsigned IN_NUM        = 2,
  parameter int unsigned OUT_NUM       = 2,
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned ENT_NUM_WIDTH = 3
);
  logic [IN_NUM-1:0]            in_vld;
  logic [IN_NUM*DATA_SIZE-1:0]  in_data;
  logic [IN_NUM-1:0]            in_rdy;
  logic [OUT_NUM-1:0]           out_vld;
  logic [OUT_NUM*DATA_SIZE-1:0] out_data;
  logic [OUT_NUM-1:0]           pick_rdy;
  logic                         fifo_full;
  logic [ENT_NUM_WIDTH:0]       ent_cnt;
`ifdef FIFO_OVF_STAT_EN
  logic                         stat_clr;
  logic                         ovf_flag;
  logic [DROP_CNT_W-1:0]        drop_cnt;
`endif

  modport master (
    output in_vld, in_data, pick_rdy,
`ifdef FIFO_OVF_STAT_EN
    output stat_clr,
    input  ovf_flag, drop_cnt,
`endif
    input  in_rdy, out_vld, out_data, fifo_full, ent_cnt
  );

  modport slave (
    input  in_vld, in_data, pick_rdy,
`ifdef FIFO_OVF_STAT_EN
    input  stat_clr,
    output ovf_flag, drop_cnt,
`endif
    output in_rdy, out_vld, out_data, fifo_full, ent_cnt
  );
endinterface

// File: rtl/lead_ones_cnt.sv
// Counts contiguous ones starting at bit 0 of vec (stops at the first zero).
//   vec : input vector
//   cnt : number of leading ones, 0..WIDTH
module lead_ones_cnt #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt
);
  logic run;

  always_comb begin
    run = 1'b1;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & vec[i];
      cnt = cnt + CNT_W'(run);
    end
  end
endmodule

// File: rtl/multi_in_multi_out_fifo_lib.sv
// Circular FIFO taking up to IN_NUM entries and releasing up to OUT_NUM entries per cycle,
// strictly in order. OVERWRITE=1 drops the oldest entries on overflow; OVERWRITE=0
// back-pressures through in_rdy (from registered occupancy only).
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : slave modport of multi_in_multi_out_fifo_lib_if (write lanes, read lanes,
//              fifo_full, ent_cnt)
// Optional: FIFO_OVF_STAT_EN adds sticky ovf_flag, saturating drop_cnt and stat_clr.
module multi_in_multi_out_fifo_lib
  import fifo_lib_pkg::*;
#(
  parameter int unsigned ENT_NUM       = 8,
  parameter int unsigned ENT_NUM_WIDTH = $clog2(ENT_NUM),
  parameter int unsigned DATA_SIZE     = 32,
  parameter int unsigned IN_NUM        = 2,
  parameter int unsigned OUT_NUM       = 2,
  parameter bit          OVERWRITE     = 1'b0
) (
  input logic clk,
  input logic rst,
  multi_in_multi_out_fifo_lib_if.slave bus
);
  localparam int unsigned PTR_W  = ptr_width(ENT_NUM);
  localparam int unsigned PUSH_W = $clog2(IN_NUM + 1);
  localparam int unsigned POP_W  = $clog2(OUT_NUM + 1);
  localparam int unsigned RAW_W  = PTR_W + 1;  // holds cnt + push before clamping
  localparam logic [RAW_W-1:0] ENT_RAW = RAW_W'(ENT_NUM);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]     free;
  logic [DATA_SIZE-1:0] mem [ENT_NUM];
  logic [IN_NUM-1:0]    in_rdy, acc;
  logic [OUT_NUM-1:0]   out_vld, take;
  logic [PUSH_W-1:0]    push;
  logic [POP_W-1:0]     pop;
  logic [RAW_W-1:0]     raw, drop;

  // Back-pressure uses registered occupancy only; a same-cycle pop gives no credit.
  always_comb begin
    free = PTR_W'(ENT_NUM) - cnt_q;
    for (int i = 0; i < IN_NUM; i++) begin
      in_rdy[i] = OVERWRITE ? 1'b1 : (free > PTR_W'(i));
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_NUM; j++) begin
      out_vld[j] = cnt_q > PTR_W'(j);
      bus.out_data[j*DATA_SIZE +: DATA_SIZE] =
        mem[ENT_NUM_WIDTH'(idx_add(32'(rd_ptr_q[ENT_NUM_WIDTH-1:0]), j, ENT_NUM))];
    end
  end

  assign acc           = bus.in_vld & in_rdy;
  assign take          = out_vld & bus.pick_rdy;
  assign bus.in_rdy    = in_rdy;
  assign bus.out_vld   = out_vld;
  assign bus.fifo_full = (cnt_q == PTR_W'(ENT_NUM));
  assign bus.ent_cnt   = cnt_q;

  lead_ones_cnt #(.WIDTH(IN_NUM), .CNT_W(PUSH_W)) u_push_cnt (.vec(acc), .cnt(push));
  lead_ones_cnt #(.WIDTH(OUT_NUM), .CNT_W(POP_W)) u_pop_cnt (.vec(take), .cnt(pop));

  // pop never exceeds cnt (out_vld is a thermometer of cnt), so raw cannot underflow.
  always_comb begin
    raw      = RAW_W'(cnt_q) + RAW_W'(push) - RAW_W'(pop);
    drop     = '0;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (OVERWRITE && (raw > ENT_RAW)) begin
      drop     = raw - ENT_RAW;
      cnt_d    = PTR_W'(ENT_NUM);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop) + PTR_W'(drop);
    end else begin
      cnt_d    = PTR_W'(raw);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; only lanes inside the accepted prefix are written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_NUM; i++) begin
      if (PUSH_W'(i) < push) begin
        mem[ENT_NUM_WIDTH'(idx_add(32'(wr_ptr_q[ENT_NUM_WIDTH-1:0]), i, ENT_NUM))] <=
          bus.in_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

`ifdef FIFO_OVF_STAT_EN
  localparam int unsigned SUM_W = DROP_CNT_W + 1;

  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PUSH_W-1:0]     refused;
  logic                  refuse_hit;
  logic [RAW_W-1:0]      lost;
  logic [SUM_W-1:0]      sum;

  // Refusal counts only when the first unaccepted lane was valid but not ready,
  // so a producer-side lane gap is not booked as a loss.
  always_comb begin
    refused    = '0;
    refuse_hit = 1'b0;
    for (int i = 0; i < IN_NUM; i++) begin
      if ((PUSH_W'(i) >= push) && bus.in_vld[i]) refused = refused + PUSH_W'(1);
      if ((PUSH_W'(i) == push) && bus.in_vld[i] && !in_rdy[i]) refuse_hit = 1'b1;
    end
    lost       = OVERWRITE ? drop : (refuse_hit ? RAW_W'(refused) : '0);
    sum        = {1'b0, (bus.stat_clr ? {DROP_CNT_W{1'b0}} : drop_cnt_q)} + SUM_W'(lost);
    drop_cnt_d = sum[DROP_CNT_W] ? DROP_CNT_MAX : sum[DROP_CNT_W-1:0];
    ovf_d      = (lost != '0) | (ovf_q & ~bus.stat_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.ovf_flag = ovf_q;
  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multi_in_multi_out_fifo_lib.sv
// Bench for multi_in_multi_out_fifo_lib: one backpressure instance (OVERWRITE=0) and one
// overwrite instance (OVERWRITE=1). A table of {lane stimulus, expected occupancy} rows is
// applied; a queue model supplies expected in_rdy/out_vld/out_data/ent_cnt/fifo_full.
module tb_multi_in_multi_out_fifo_lib;

  typedef struct {
    int         k;        // 0: backpressure instance, 1: overwrite instance
    logic [1:0] vld;
    logic [1:0] pick;
    int         exp_cnt;  // occupancy expected before this row's clock edge
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_in_multi_out_fifo_lib_if #(.IN_NUM(2), .OUT_NUM(2), .DATA_SIZE(32),
                                   .ENT_NUM_WIDTH(3)) bus0 ();
  multi_in_multi_out_fifo_lib_if #(.IN_NUM(2), .OUT_NUM(2), .DATA_SIZE(32),
                                   .ENT_NUM_WIDTH(3)) bus1 ();

  multi_in_multi_out_fifo_lib #(.ENT_NUM(8), .DATA_SIZE(32), .IN_NUM(2), .OUT_NUM(2),
                                .OVERWRITE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  multi_in_multi_out_fifo_lib #(.ENT_NUM(8), .DATA_SIZE(32), .IN_NUM(2), .OUT_NUM(2),
                                .OVERWRITE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] next_data = 32'hA000_0000;
  vec_t        tbl[$];
  int          viol0 = 0;
  int          viol1 = 0;
`ifdef FIFO_OVF_STAT_EN
  int          st_drop[2];
  bit          st_ovf[2];
`endif

  // Protocol monitor: a valid lane above an invalid one is a lane-order violation.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus0.in_vld[1] && !bus0.in_vld[0]) viol0 <= viol0 + 1;
      if (bus1.in_vld[1] && !bus1.in_vld[0]) viol1 <= viol1 + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int k, input logic [1:0] vld, input logic [1:0] pick,
                     input int exp_cnt);
    tbl.push_back('{k: k, vld: vld, pick: pick, exp_cnt: exp_cnt});
  endtask

  // Called at a negedge: drive, check before the edge, advance the model across the edge.
  task automatic step(input int k, input logic [1:0] vld, input logic [1:0] pick,
                      input int exp_cnt, input string tag);
    logic [31:0] q[$];
    logic [1:0]  rdy_e, ovld_e, a_rdy, a_ovld;
    logic [63:0] a_data;
    logic [3:0]  a_cnt;
    logic        a_full;
    int          n, push, pop, lost;
    if (k == 0) q = q0; else q = q1;
    n = q.size();
    for (int i = 0; i < 2; i++) begin
      rdy_e[i]  = (k == 1) || ((8 - n) > i);
      ovld_e[i] = n > i;
    end
    bus0.in_vld   = (k == 0) ? vld : 2'b00;
    bus0.pick_rdy = (k == 0) ? pick : 2'b00;
    bus0.in_data  = {next_data + 32'd1, next_data};
    bus1.in_vld   = (k == 1) ? vld : 2'b00;
    bus1.pick_rdy = (k == 1) ? pick : 2'b00;
    bus1.in_data  = {next_data + 32'd1, next_data};
    #1;
    if (k == 0) begin
      a_rdy = bus0.in_rdy; a_ovld = bus0.out_vld; a_data = bus0.out_data;
      a_cnt = bus0.ent_cnt; a_full = bus0.fifo_full;
    end else begin
      a_rdy = bus1.in_rdy; a_ovld = bus1.out_vld; a_data = bus1.out_data;
      a_cnt = bus1.ent_cnt; a_full = bus1.fifo_full;
    end
    chk($sformatf("%s in_rdy", tag), 64'(a_rdy), 64'(rdy_e));
    chk($sformatf("%s out_vld", tag), 64'(a_ovld), 64'(ovld_e));
    chk($sformatf("%s ent_cnt", tag), 64'(a_cnt), 64'(n));
    chk($sformatf("%s ent_cnt_tbl", tag), 64'(a_cnt), 64'(exp_cnt));
    chk($sformatf("%s fifo_full", tag), 64'(a_full), 64'(n == 8));
    for (int j = 0; j < 2; j++) begin
      if (j < n) chk($sformatf("%s out_data[%0d]", tag, j), 64'(a_data[j*32 +: 32]),
                     64'(q[j]));
    end
    push = 0;
    while (push < 2 && vld[push] && rdy_e[push]) push++;
    pop = 0;
    while (pop < 2 && ovld_e[pop] && pick[pop]) pop++;
    lost = 0;
    if (k == 0) begin
      if (push < 2 && vld[push] && !rdy_e[push]) begin
        for (int i = push; i < 2; i++) lost += int'(vld[i]);
      end
    end else if (n - pop + push > 8) begin
      lost = n - pop + push - 8;
    end
    @(posedge clk);
    repeat (pop) void'(q.pop_front());
    for (int i = 0; i < push; i++) q.push_back(next_data + 32'(i));
    while (q.size() > 8) void'(q.pop_front());
    next_data = next_data + 32'(push);
    if (k == 0) q0 = q; else q1 = q;
`ifdef FIFO_OVF_STAT_EN
    if (lost > 0) st_ovf[k] = 1'b1;
    st_drop[k] = (st_drop[k] + lost > 65535) ? 65535 : st_drop[k] + lost;
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus0.in_vld = '0; bus0.in_data = '0; bus0.pick_rdy = '0;
    bus1.in_vld = '0; bus1.in_data = '0; bus1.pick_rdy = '0;
`ifdef FIFO_OVF_STAT_EN
    bus0.stat_clr = 1'b0; bus1.stat_clr = 1'b0;
    st_drop[0] = 0; st_drop[1] = 0; st_ovf[0] = 1'b0; st_ovf[1] = 1'b0;
`endif

    // Backpressure instance: fill, full+pick, wrap, drain, lane gaps, partial ready.
    add(0, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b00, 2 * i);
    add(0, 2'b11, 2'b11, 8);
    add(0, 2'b00, 2'b00, 6);
    for (int i = 0; i < 12; i++) add(0, 2'b11, 2'b11, 6);
    for (int i = 0; i < 3; i++) add(0, 2'b00, 2'b11, 6 - 2 * i);
    add(0, 2'b10, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0);
    add(0, 2'b01, 2'b00, 0);
    add(0, 2'b00, 2'b10, 1);
    for (int i = 0; i < 4; i++) add(0, 2'b11, 2'b00, 1 + 2 * i);
    for (int i = 0; i < 4; i++) add(0, 2'b00, 2'b11, 8 - 2 * i);
    add(0, 2'b00, 2'b00, 0);
    // Overwrite instance: fill, overflow, overflow with partial pop, push+pop at full.
    add(1, 2'b00, 2'b00, 0);
    for (int i = 0; i < 4; i++) add(1, 2'b11, 2'b00, 2 * i);
    add(1, 2'b11, 2'b00, 8);
    add(1, 2'b00, 2'b00, 8);
    add(1, 2'b11, 2'b01, 8);
    add(1, 2'b11, 2'b11, 8);
    for (int i = 0; i < 4; i++) add(1, 2'b00, 2'b11, 8 - 2 * i);
    add(1, 2'b00, 2'b00, 0);

    // Reset state, checked while rst is held.
    #2;
    chk("rst in_rdy0", 64'(bus0.in_rdy), 64'(2'b11));
    chk("rst in_rdy1", 64'(bus1.in_rdy), 64'(2'b11));
    chk("rst out_vld0", 64'(bus0.out_vld), 64'(2'b00));
    chk("rst ent_cnt0", 64'(bus0.ent_cnt), 64'(0));
    chk("rst fifo_full0", 64'(bus0.fifo_full), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].k, tbl[r].vld, tbl[r].pick, tbl[r].exp_cnt, $sformatf("row%0d", r));
    end
    bus1.in_vld = '0; bus1.pick_rdy = '0;

    chk("gap_viol0", 64'(viol0), 64'(1));
    chk("gap_viol1", 64'(viol1), 64'(0));

`ifdef FIFO_OVF_STAT_EN
    chk("ovf_flag0", 64'(bus0.ovf_flag), 64'(st_ovf[0]));
    chk("drop_cnt0", 64'(bus0.drop_cnt), 64'(st_drop[0]));
    chk("ovf_flag1", 64'(bus1.ovf_flag), 64'(st_ovf[1]));
    chk("drop_cnt1", 64'(bus1.drop_cnt), 64'(st_drop[1]));
    chk("drop_cnt1_abs", 64'(bus1.drop_cnt), 64'(3));
    bus0.stat_clr = 1'b1; bus1.stat_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    bus0.stat_clr = 1'b0; bus1.stat_clr = 1'b0;
    #1;
    chk("clr ovf_flag1", 64'(bus1.ovf_flag), 64'(0));
    chk("clr drop_cnt1", 64'(bus1.drop_cnt), 64'(0));
    chk("clr drop_cnt0", 64'(bus0.drop_cnt), 64'(0));
    @(negedge clk);
    st_drop[0] = 0; st_drop[1] = 0; st_ovf[0] = 1'b0; st_ovf[1] = 1'b0;
`endif

    // Reset asserted mid-burst: occupancy clears at once, in-flight lanes are ignored.
    step(0, 2'b11, 2'b00, 0, "burst0");
    step(0, 2'b11, 2'b00, 2, "burst1");
    bus0.in_vld  = 2'b11;
    bus0.in_data = {next_data + 32'd1, next_data};
    #2 rst = 1'b1;
    #1;
    chk("midrst ent_cnt", 64'(bus0.ent_cnt), 64'(0));
    chk("midrst out_vld", 64'(bus0.out_vld), 64'(0));
    chk("midrst in_rdy", 64'(bus0.in_rdy), 64'(2'b11));
    chk("midrst fifo_full", 64'(bus0.fifo_full), 64'(0));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bus0.in_vld = '0;
    q0.delete(); q1.delete();
    step(0, 2'b00, 2'b00, 0, "post_rst");
    step(0, 2'b01, 2'b00, 0, "post_rst_wr");
    step(0, 2'b00, 2'b01, 1, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
